spi_peripheral: RTL
===================

// Module: spi_peripheral
// PURPOSE
// - SPI target (mode 0) feeding the PWM stage of tt_um_uwasic_onboarding_samuel_zhang; lives in the user project top.
// - Pins arrive on ui_in: sclk=ui_in[0], copi=ui_in[1], ncs=ui_in[2]. Decoded writes land in a 5-entry write-mostly register file.
// - Register outputs drive the downstream PWM block directly: output enables, PWM enables, duty cycle.
// - All SPI pins are treated as asynchronous to clk and are oversampled: clk must be >= 4x sclk.
// PARAMETERS
// - SYNC_STAGES  2     flops per input synchroniser; legal range 2..3
// - NUM_REGS     5     implemented addresses 0..NUM_REGS-1
// - ADDR_W       7     address field width in the SPI frame
// PORTS
// - clk              in   1  system clock
// - rst_n            in   1  asynchronous active-low reset
// - sclk_i           in   1  SPI clock, async
// - copi_i           in   1  SPI data in, async
// - ncs_i            in   1  SPI chip select, active low, async
// - cipo_o           out  1  SPI data out (readback only)
// - cipo_oe_o        out  1  cipo output enable, for uio_oe
// - en_reg_out_7_0   out  8  addr 0x00: output enable uo_out[7:0]
// - en_reg_out_15_8  out  8  addr 0x01: output enable uio_out[7:0]
// - en_reg_pwm_7_0   out  8  addr 0x02: PWM enable uo_out[7:0]
// - en_reg_pwm_15_8  out  8  addr 0x03: PWM enable uio_out[7:0]
// - pwm_duty_cycle   out  8  addr 0x04: duty, 0x00=0%, 0xFF=100%
// BEHAVIOUR
// - Reset: all five registers 0x00; cipo_o=0; cipo_oe_o=0; bit counter 0; shift reg 0; FSM IDLE; sync flops: sclk/copi 0, ncs 1.
// - Frame: 16 bits, MSB first, sampled on synchronised sclk rising edge: [15]=R/W (1=write), [14:8]=addr, [7:0]=data.
// - Edge detect: compare last two sync stages of sclk/ncs; one-clk pulses sclk_rise, sclk_fall, ncs_fall, ncs_rise.
// - FSM: IDLE -(ncs_fall)-> SHIFT. SHIFT -(ncs_rise)-> COMMIT. COMMIT -> IDLE after 1 clk.
// - SHIFT: each sclk_rise shifts copi into shift reg, count++. Count saturates at 16; extra bits do not shift.
// - COMMIT conditions, all required: count==16, R/W=1, addr<NUM_REGS. Write takes effect 1 clk after ncs_rise is detected.
// - Latency: ncs pin rise to register update = SYNC_STAGES+2 clk.
// - Discard cases, no register changes: count!=16 (short or long frame); R/W=0; addr>=NUM_REGS.
// - Only one register updates per frame. Other registers hold their values.
// - sclk edges while ncs is high are ignored. A ncs_fall while in SHIFT is impossible; a ncs_rise while in IDLE is ignored.
// - If ncs_rise and sclk_rise occur in the same clk, ncs_rise wins and that bit is not counted.
// - Reset asserted mid-frame: immediate return to reset state. The frame is lost and registers are 0x00.
// CONFIGURATION
// - Macro SPI_READBACK_EN.
// - Defined: when count reaches 8 and R/W=0, load the register at addr into the readback shifter; out-of-range addr loads 0x00.
//   cipo_o presents the MSB on the next sclk_fall, then shifts on each later sclk_fall.
//   cipo_oe_o=1 only while ncs is low in a read frame after count>=8; it deasserts on ncs_rise.
// - Undefined: cipo_o and cipo_oe_o are tied to 0, no readback shifter is built, and read frames are discarded silently.
// STRUCTURE
// - Package spi_peripheral_pkg:
//   - address localparams ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4
//   - FRAME_BITS=16
//   - typedef enum {IDLE, SHIFT, COMMIT} spi_state_t
// - Sub-module sync_edge_det, instantiated 3x: SYNC_STAGES synchroniser plus rise/fall pulse outputs, reset to a parameterised idle level.
// - Top level: FSM, bit counter, shift register, register file, optional readback shifter.
// TESTING
// - Use clk 10 MHz and sclk 1 MHz via ui_in. All values below are the 16-bit frame.
// - Write 0x80F0 -> en_reg_out_7_0=0xF0 within SYNC_STAGES+2 clk of ncs high; other regs stay 0x00.
// - Write 0x8480, then 0x1F55 (R/W=0) -> pwm_duty_cycle stays 0x80.
// - Write 0x9099 (addr 0x10) -> all regs unchanged. Then a 15-bit frame 0x82.. with ncs raised early -> unchanged.
// - Write 0x83AA, then assert rst_n=0 mid-way through the next frame -> every reg 0x00 and cipo_oe_o=0 within 1 clk.
// - Back-to-back writes 0x8101, 0x8202 with 2 clk ncs-high gap -> both regs updated.
// - SPI_READBACK_EN: write 0x8433, then read 0x0400 -> cipo bits[7:0] read 0x33 and cipo_oe_o falls on ncs high.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared constants and FSM encoding for the SPI register-file target.
// Register map addresses, frame length and the frame-tracking state type.
package spi_peripheral_pkg;

    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;

    localparam int FRAME_BITS = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_peripheral_sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous pin, with one-clk rise/fall pulses.
// The extra history flop after the last sync stage is what the pulses compare against.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES:0] sync_q;
    logic [SYNC_STAGES:0] sync_d;

    // Shift the pin in at stage 0; the top bit holds the previous synchronised level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-1:0], d_i};
    end

    // Synchroniser and history flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {(SYNC_STAGES+1){RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];

endmodule

// File: rtl/spi_peripheral.sv
// Mode-0 SPI target writing a 5-entry register file that drives the PWM stage.
// Optional readback path (cipo) is built only when SPI_READBACK_EN is defined.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_i,
    input  logic       copi_i,
    input  logic       ncs_i,
    output logic       cipo_o,
    output logic       cipo_oe_o,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [4:0]        CNT_MAX     = 5'(FRAME_BITS);
    localparam logic [ADDR_W-1:0] NUM_REGS_A  = ADDR_W'(NUM_REGS);

    logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
    logic copi_s, copi_rise_s, copi_fall_s;
    logic ncs_lvl_s, ncs_rise_s, ncs_fall_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
        .level_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi_i),
        .level_o(copi_s), .rise_o(copi_rise_s), .fall_o(copi_fall_s)
    );
    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs_i),
        .level_o(ncs_lvl_s), .rise_o(ncs_rise_s), .fall_o(ncs_fall_s)
    );

    spi_state_t                state_q, state_d;
    logic [4:0]                count_q, count_d;
    logic [FRAME_BITS-1:0]     shift_q, shift_d;
    logic                      ovf_q, ovf_d;
    logic [7:0]                regs_q [NUM_REGS];
    logic [7:0]                regs_d [NUM_REGS];
    logic [ADDR_W-1:0]         addr_s;
    logic                      frame_ok_s;

    // A long frame saturates the count at 16 but is flagged so it can still be discarded.
    assign addr_s     = shift_q[14:8];
    assign frame_ok_s = (count_q == CNT_MAX) && !ovf_q && shift_q[15] && (addr_s < NUM_REGS_A);

    // Frame FSM, bit counter, shift register and register-file write.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        ovf_d   = ovf_q;
        regs_d  = regs_q;
        case (state_q)
            IDLE: begin
                if (ncs_fall_s) begin
                    state_d = SHIFT;
                    count_d = 5'd0;
                    shift_d = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (ncs_rise_s) begin
                    state_d = COMMIT;
                end else if (sclk_rise_s) begin
                    if (count_q == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
                        count_d = count_q + 5'd1;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (frame_ok_s && (addr_s == ADDR_W'(i))) begin
                        regs_d[i] = shift_q[7:0];
                    end else begin
                        regs_d[i] = regs_q[i];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame state and register file flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= 5'd0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            regs_q  <= regs_d;
        end
    end

    assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_q[ADDR_DUTY];

`ifdef SPI_READBACK_EN
    logic [7:0]        rb_q, rb_d;
    logic              cipo_q, cipo_d;
    logic              oe_q, oe_d;
    logic              rd_load_s;
    logic [ADDR_W-1:0] rd_addr_s;

    // The 8th bit is arriving now: shift_q[6] becomes R/W, the address completes with copi.
    assign rd_load_s = (state_q == SHIFT) && !ncs_rise_s && sclk_rise_s
                       && (count_q == 5'd7) && !shift_q[6];
    assign rd_addr_s = {shift_q[5:0], copi_s};

    // Readback shifter: load at byte boundary, present MSB first on each sclk fall.
    always_comb begin
        rb_d   = rb_q;
        cipo_d = cipo_q;
        oe_d   = oe_q;
        if ((state_q != SHIFT) || ncs_rise_s) begin
            oe_d   = 1'b0;
            cipo_d = 1'b0;
        end else if (rd_load_s) begin
            oe_d = 1'b1;
            rb_d = 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_addr_s == ADDR_W'(i)) begin
                    rb_d = regs_q[i];
                end else begin
                    rb_d = rb_d;
                end
            end
        end else if (oe_q && sclk_fall_s) begin
            cipo_d = rb_q[7];
            rb_d   = {rb_q[6:0], 1'b0};
        end else begin
            rb_d = rb_q;
        end
    end

    // Readback flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q   <= 8'h00;
            cipo_q <= 1'b0;
            oe_q   <= 1'b0;
        end else begin
            rb_q   <= rb_d;
            cipo_q <= cipo_d;
            oe_q   <= oe_d;
        end
    end

    assign cipo_o    = cipo_q;
    assign cipo_oe_o = oe_q;
`else
    assign cipo_o    = 1'b0;
    assign cipo_oe_o = 1'b0;
`endif

    logic unused_s;
    assign unused_s = ^{sclk_lvl_s, sclk_fall_s, copi_rise_s, copi_fall_s, ncs_lvl_s};

endmodule
